// File: rtl/dequant_sprime_writer_if.sv
// Bundle of the dequantizer's start/control inputs, the coefficient stream
// and the SRAM write port.
//   master : upstream source / frame controller (drives start, Q_sel, coeff_*)
//   slave  : dequant_sprime_writer (drives coeff_ready, SRAM_*, done pulses)
//
// Handshake: a coefficient moves on the rising clock edge where
// coeff_valid && coeff_ready are both 1. The source holds coeff_data stable
// while coeff_valid=1 and coeff_ready=0; coeff_ready never depends on
// coeff_valid in the same cycle.
interface dequant_sprime_writer_if;
  logic        DQ_start;
  logic        Q_sel;
  logic        coeff_valid;
  logic [15:0] coeff_data;
  logic        coeff_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        block_done;
  logic        DQ_done;
  logic [1:0]  state_dbg;   // FSM state: 0 IDLE, 1 RUN, 2 FLUSH, 3 DONE

  modport master (
    output DQ_start, Q_sel, coeff_valid, coeff_data,
    input  coeff_ready, SRAM_address, SRAM_write_data, SRAM_we_n,
           block_done, DQ_done, state_dbg
  );

  modport slave (
    input  DQ_start, Q_sel, coeff_valid, coeff_data,
    output coeff_ready, SRAM_address, SRAM_write_data, SRAM_we_n,
           block_done, DQ_done, state_dbg
  );
endinterface

// File: rtl/dequant_sprime_writer.sv
// dequant_sprime_writer
// Takes quantized coefficients (64 per 8x8 block, JPEG zigzag order),
// dequantizes each with a power-of-two Q matrix and writes the S' word into
// the pre-IDCT SRAM region in row-major image order. Block order is all Y
// blocks, then all U blocks, then all V blocks, raster order within a plane.
// Ports:
//   CLOCK_50_I : system clock
//   Resetn     : asynchronous active-low reset
//   bus        : dequant_sprime_writer_if.slave (start, Q_sel, coefficient
//                stream, SRAM write port, block_done / DQ_done pulses,
//                state_dbg)
module dequant_sprime_writer #(
  parameter int SPRIME_BASE = 76800,
  parameter int Y_WIDTH     = 320,
  parameter int HEIGHT      = 240
) (
  input  logic                     CLOCK_50_I,
  input  logic                     Resetn,
  dequant_sprime_writer_if.slave   bus
);

  localparam logic [17:0] Y_BASE  = 18'(SPRIME_BASE);
  localparam logic [17:0] U_BASE  = 18'(SPRIME_BASE + Y_WIDTH * HEIGHT);
  localparam logic [17:0] V_BASE  = 18'(SPRIME_BASE + Y_WIDTH * HEIGHT + (Y_WIDTH / 2) * HEIGHT);
  localparam logic [17:0] Y_W     = 18'(Y_WIDTH);
  localparam logic [17:0] C_W     = 18'(Y_WIDTH / 2);
  localparam logic [5:0]  Y_BC_LAST = 6'(Y_WIDTH / 8 - 1);
  localparam logic [5:0]  C_BC_LAST = 6'(Y_WIDTH / 16 - 1);
  localparam logic [4:0]  BR_LAST   = 5'(HEIGHT / 8 - 1);

  // Zigzag index -> natural index 8*r + c within the 8x8 block.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

  logic [5:0] k;
  logic [5:0] bc;
  logic [4:0] br;
  logic [1:0] seg;
  logic       q_sel_r;

  logic accept, k_last, bc_last, br_last, seg_last, frame_last;
  logic [5:0]  zz_n;
  logic [2:0]  r, c;
  logic [3:0]  s;
  logic [2:0]  sh;
  logic [17:0] row18, col18, row_w, base, addr_nxt;
  logic signed [21:0] wide, shifted;
  logic [15:0] dq_val;

  assign accept     = bus.coeff_valid && (state == RUN);
  assign k_last     = (k == 6'd63);
  assign bc_last    = (bc == ((seg == 2'd0) ? Y_BC_LAST : C_BC_LAST));
  assign br_last    = (br == BR_LAST);
  assign seg_last   = (seg == 2'd2);
  assign frame_last = k_last && bc_last && br_last && seg_last;

  // Position of the current coefficient inside its block.
  assign zz_n = ZZ[k];
  assign r    = zz_n[5:3];
  assign c    = zz_n[2:0];

  // Image address: base(seg) + (8*br + r)*W + 8*bc + c.
  assign row18    = 18'({br, 3'b000}) + 18'(r);
  assign col18    = 18'({bc, 3'b000}) + 18'(c);
  assign row_w    = row18 * ((seg == 2'd0) ? Y_W : C_W);
  assign base     = (seg == 2'd0) ? Y_BASE : ((seg == 2'd1) ? U_BASE : V_BASE);
  assign addr_nxt = base + row_w + col18;

  // Shift amount depends on the anti-diagonal r+c and the latched Q matrix.
  assign s = {1'b0, r} + {1'b0, c};

  always_comb begin
    sh = 3'd0;
    if (!q_sel_r) begin
      if      (s == 4'd0) sh = 3'd3;
      else if (s == 4'd1) sh = 3'd2;
      else if (s <= 4'd3) sh = 3'd3;
      else if (s <= 4'd5) sh = 3'd4;
      else if (s <= 4'd7) sh = 3'd5;
      else                sh = 3'd6;
    end else begin
      if      (s == 4'd0) sh = 3'd3;
      else if (s <= 4'd3) sh = 3'd1;
      else if (s <= 4'd5) sh = 3'd2;
      else if (s <= 4'd7) sh = 3'd3;
      else                sh = 3'd4;
    end
  end

  // 16-bit input shifted by at most 6 fits in 22 bits; clamp back to 16.
  assign wide    = {{6{bus.coeff_data[15]}}, bus.coeff_data};
  assign shifted = wide <<< sh;

  always_comb begin
    dq_val = shifted[15:0];
    if (shifted > 22'sd32767)       dq_val = 16'h7FFF;
    else if (shifted < -22'sd32768) dq_val = 16'h8000;
  end

  // FSM
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.DQ_start) state_nxt = RUN;
      RUN:     if (accept && frame_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.coeff_ready = (state == RUN);
  assign bus.DQ_done     = (state == DONE);
  assign bus.state_dbg   = state;

  // Block position counters; a fresh start always begins at Y block (0,0).
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      k       <= 6'd0;
      bc      <= 6'd0;
      br      <= 5'd0;
      seg     <= 2'd0;
      q_sel_r <= 1'b0;
    end else if (state == IDLE && bus.DQ_start) begin
      k       <= 6'd0;
      bc      <= 6'd0;
      br      <= 5'd0;
      seg     <= 2'd0;
      q_sel_r <= bus.Q_sel;
    end else if (accept) begin
      k <= k + 6'd1;
      if (k_last) begin
        if (bc_last) begin
          bc <= 6'd0;
          if (br_last) begin
            br  <= 5'd0;
            seg <= seg_last ? 2'd0 : seg + 2'd1;
          end else begin
            br <= br + 5'd1;
          end
        end else begin
          bc <= bc + 6'd1;
        end
      end
    end
  end

  // Registered SRAM port: the write lands one cycle after acceptance.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      bus.SRAM_address    <= 18'd0;
      bus.SRAM_write_data <= 16'd0;
      bus.SRAM_we_n       <= 1'b1;
      bus.block_done      <= 1'b0;
    end else begin
      bus.SRAM_we_n  <= !accept;
      bus.block_done <= accept && k_last;
      if (accept) begin
        bus.SRAM_address    <= addr_nxt;
        bus.SRAM_write_data <= dq_val;
      end
    end
  end

endmodule

// File: tb/tb_dequant_sprime_writer.sv
// Testbench for dequant_sprime_writer.
// ifa/dut_a : default frame geometry (320x240 at 76800), directed vectors.
// ifs/dut_s : reduced geometry (32x16 at 1000) so whole frames, U/V bases and
//             stall behaviour can be exercised quickly against an expected queue.
module tb_dequant_sprime_writer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dequant_sprime_writer_if ifa ();
  dequant_sprime_writer_if ifs ();

  dequant_sprime_writer dut_a (
    .CLOCK_50_I (clk),
    .Resetn     (rst_n),
    .bus        (ifa)
  );

  dequant_sprime_writer #(
    .SPRIME_BASE (1000),
    .Y_WIDTH     (32),
    .HEIGHT      (16)
  ) dut_s (
    .CLOCK_50_I (clk),
    .Resetn     (rst_n),
    .bus        (ifs)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    ifa.DQ_start = 1'b0; ifa.Q_sel = 1'b0; ifa.coeff_valid = 1'b0; ifa.coeff_data = 16'd0;
    ifs.DQ_start = 1'b0; ifs.Q_sel = 1'b0; ifs.coeff_valid = 1'b0; ifs.coeff_data = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- monitors ----------------
  int bd_cnt_a = 0;
  always @(negedge clk) if (ifa.block_done === 1'b1) bd_cnt_a++;

  logic [33:0] wr_s_q[$];
  int   bd_cnt_s = 0, dd_cnt_s = 0, we_err_s = 0;
  int   cyc_s = 0, last_wr_cyc = 0, dd_cyc = 0;
  logic acc_prev = 1'b0;

  always @(negedge clk) begin
    cyc_s++;
    if (rst_n === 1'b1) begin
      if (ifs.SRAM_we_n === 1'b0) begin
        wr_s_q.push_back({ifs.SRAM_address, ifs.SRAM_write_data});
        last_wr_cyc = cyc_s;
      end
      // A write may appear only in the cycle right after an acceptance.
      if (ifs.SRAM_we_n !== (acc_prev ? 1'b0 : 1'b1)) we_err_s++;
      if (ifs.block_done === 1'b1) bd_cnt_s++;
      if (ifs.DQ_done === 1'b1) begin dd_cnt_s++; dd_cyc = cyc_s; end
      acc_prev = (ifs.coeff_valid === 1'b1) && (ifs.coeff_ready === 1'b1);
    end else begin
      acc_prev = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic start_a(input logic q);
    ifa.Q_sel = q; ifa.DQ_start = 1'b1;
    @(posedge clk); #1;
    ifa.DQ_start = 1'b0; ifa.Q_sel = ~q;
  endtask

  task automatic start_s(input logic q);
    ifs.Q_sel = q; ifs.DQ_start = 1'b1;
    @(posedge clk); #1;
    ifs.DQ_start = 1'b0; ifs.Q_sel = ~q;
  endtask

  // Returns #1 after the accepting edge, when the registered write is visible.
  task automatic drive_a(input logic [15:0] d);
    int n;
    n = 0;
    ifa.coeff_valid = 1'b1; ifa.coeff_data = d;
    while (ifa.coeff_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL drive_a_timeout: coeff_ready=%b required 1", ifa.coeff_ready);
    end
    @(posedge clk); #1;
    ifa.coeff_valid = 1'b0;
  endtask

  task automatic drive_s(input logic [15:0] d);
    int n;
    n = 0;
    ifs.coeff_valid = 1'b1; ifs.coeff_data = d;
    while (ifs.coeff_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL drive_s_timeout: coeff_ready=%b required 1", ifs.coeff_ready);
    end
    @(posedge clk); #1;
    ifs.coeff_valid = 1'b0;
  endtask

  // ---------------- reference model for the small instance ----------------
  int zz[64] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
                 12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
                 35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                 58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  logic [33:0] exp_q[$];

  function automatic int coeff_pat(input int i);
    if (i % 97 == 5) return 2000;
    if (i % 89 == 3) return -2000;
    return ((i * 37) % 401) - 200;
  endfunction

  function automatic int shift_model(input logic q, input int s);
    if (s == 0) return 3;
    if (s == 1) return q ? 1 : 2;
    if (s <= 3) return q ? 1 : 3;
    if (s <= 5) return q ? 2 : 4;
    if (s <= 7) return q ? 3 : 5;
    return q ? 4 : 6;
  endfunction

  task automatic build_exp(input logic q);
    int idx, w, base, n, r, c, addr, v;
    logic [17:0] a18;
    logic [15:0] d16;
    exp_q.delete();
    idx = 0;
    for (int sg = 0; sg < 3; sg++) begin
      w    = (sg == 0) ? 32 : 16;
      base = (sg == 0) ? 1000 : ((sg == 1) ? 1000 + 32 * 16 : 1000 + 32 * 16 + 16 * 16);
      for (int brr = 0; brr < 2; brr++)
        for (int bcc = 0; bcc < w / 8; bcc++)
          for (int kk = 0; kk < 64; kk++) begin
            n = zz[kk]; r = n / 8; c = n % 8;
            addr = base + (8 * brr + r) * w + 8 * bcc + c;
            v = coeff_pat(idx) * (1 << shift_model(q, r + c));
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            a18 = 18'(addr); d16 = 16'(v);
            exp_q.push_back({a18, d16});
            idx++;
          end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.SRAM_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", ifa.SRAM_we_n); end
    checks++; if (ifa.SRAM_address !== 18'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %h expected 0000", ifa.SRAM_write_data); end
    checks++; if (ifa.coeff_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ifa.coeff_ready); end
    checks++; if (ifa.block_done !== 1'b0) begin errors++; $display("FAIL reset_block_done: got %b expected 0", ifa.block_done); end
    checks++; if (ifa.DQ_done !== 1'b0) begin errors++; $display("FAIL reset_dq_done: got %b expected 0", ifa.DQ_done); end
    checks++; if (ifa.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", ifa.state_dbg); end
    do_reset();
  endtask

  task automatic test_q0_first_block();
    int base;
    do_reset();
    // valid while idle must not be consumed
    ifa.coeff_valid = 1'b1; ifa.coeff_data = 16'd5;
    repeat (3) @(posedge clk); #1;
    checks++; if (ifa.SRAM_we_n !== 1'b1) begin errors++; $display("FAIL idle_no_write: we_n=%b expected 1", ifa.SRAM_we_n); end
    checks++; if (ifa.coeff_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", ifa.coeff_ready); end
    start_a(1'b0);
    base = bd_cnt_a;
    drive_a(16'd5);   // k0 (0,0) shift 3
    checks++; if (ifa.SRAM_we_n !== 1'b0) begin errors++; $display("FAIL q0_k0_we: got %b expected 0", ifa.SRAM_we_n); end
    checks++; if (ifa.SRAM_address !== 18'd76800) begin errors++; $display("FAIL q0_k0_addr: got %0d expected 76800", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'd40) begin errors++; $display("FAIL q0_k0_data: got %h expected 0028", ifa.SRAM_write_data); end
    checks++; if (ifa.block_done !== 1'b0) begin errors++; $display("FAIL q0_k0_block_done: got %b expected 0", ifa.block_done); end
    drive_a(16'hFFFD); // k1 (0,1) = -3, shift 2 -> -12
    checks++; if (ifa.SRAM_address !== 18'd76801) begin errors++; $display("FAIL q0_k1_addr: got %0d expected 76801", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'hFFF4) begin errors++; $display("FAIL q0_k1_data: got %h expected fff4", ifa.SRAM_write_data); end
    drive_a(16'd7);    // k2 (1,0), r+c=1 -> shift 2 -> 28
    checks++; if (ifa.SRAM_address !== 18'd77120) begin errors++; $display("FAIL q0_k2_addr: got %0d expected 77120", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'd28) begin errors++; $display("FAIL q0_k2_data: got %h expected 001c", ifa.SRAM_write_data); end
    @(posedge clk); #1; // stall cycle
    checks++; if (ifa.SRAM_we_n !== 1'b1) begin errors++; $display("FAIL q0_stall_we: got %b expected 1", ifa.SRAM_we_n); end
    for (int i = 3; i < 63; i++) drive_a(16'd0);
    drive_a(16'd2000); // k63 (7,7), shift 6 -> 128000 saturates
    checks++; if (ifa.SRAM_address !== 18'd79047) begin errors++; $display("FAIL q0_k63_addr: got %0d expected 79047", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'h7FFF) begin errors++; $display("FAIL q0_k63_sat_pos: got %h expected 7fff", ifa.SRAM_write_data); end
    checks++; if (ifa.block_done !== 1'b1) begin errors++; $display("FAIL q0_k63_block_done: got %b expected 1", ifa.block_done); end
    // start pulse and Q_sel change mid-frame must be ignored
    ifa.Q_sel = 1'b1; ifa.DQ_start = 1'b1;
    drive_a(16'd0);    // block (0,1) k0
    ifa.DQ_start = 1'b0;
    drive_a(16'hFFFD); // block (0,1) k1 -> 76800+8+1, still Q0
    checks++; if (ifa.SRAM_address !== 18'd76809) begin errors++; $display("FAIL blk1_k1_addr: got %0d expected 76809", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'hFFF4) begin errors++; $display("FAIL blk1_k1_data: got %h expected fff4", ifa.SRAM_write_data); end
    for (int i = 2; i < 63; i++) drive_a(16'd0);
    drive_a(16'hF830); // -2000 -> saturates negative
    checks++; if (ifa.SRAM_address !== 18'd79055) begin errors++; $display("FAIL blk1_k63_addr: got %0d expected 79055", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'h8000) begin errors++; $display("FAIL q0_k63_sat_neg: got %h expected 8000", ifa.SRAM_write_data); end
    checks++; if (ifa.block_done !== 1'b1) begin errors++; $display("FAIL blk1_block_done: got %b expected 1", ifa.block_done); end
    for (int b = 2; b < 40; b++)
      for (int i = 0; i < 64; i++) drive_a(16'd0);
    drive_a(16'd5);    // block 40 = (br 1, bc 0), k0
    checks++; if (ifa.SRAM_address !== 18'd79360) begin errors++; $display("FAIL blk40_k0_addr: got %0d expected 79360", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'd40) begin errors++; $display("FAIL blk40_k0_data: got %h expected 0028", ifa.SRAM_write_data); end
    checks++; if (bd_cnt_a - base !== 40) begin errors++; $display("FAIL blk40_block_done_count: got %0d expected 40", bd_cnt_a - base); end
  endtask

  task automatic test_q1();
    do_reset();
    start_a(1'b1);
    drive_a(16'd1);    // k0 shift 3 -> 8
    checks++; if (ifa.SRAM_write_data !== 16'd8) begin errors++; $display("FAIL q1_k0_data: got %h expected 0008", ifa.SRAM_write_data); end
    drive_a(16'hFFFD); // k1 shift 1 -> -6
    checks++; if (ifa.SRAM_address !== 18'd76801) begin errors++; $display("FAIL q1_k1_addr: got %0d expected 76801", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'hFFFA) begin errors++; $display("FAIL q1_k1_data: got %h expected fffa", ifa.SRAM_write_data); end
    for (int i = 2; i < 63; i++) drive_a(16'd0);
    drive_a(16'd2);    // k63 shift 4 -> 32
    checks++; if (ifa.SRAM_address !== 18'd79047) begin errors++; $display("FAIL q1_k63_addr: got %0d expected 79047", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'd32) begin errors++; $display("FAIL q1_k63_data: got %h expected 0020", ifa.SRAM_write_data); end
    checks++; if (ifa.block_done !== 1'b1) begin errors++; $display("FAIL q1_k63_block_done: got %b expected 1", ifa.block_done); end
  endtask

  task automatic test_abort_restart();
    do_reset();
    start_a(1'b0);
    for (int i = 0; i < 1000; i++) drive_a(16'd1);
    ifa.coeff_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.SRAM_we_n !== 1'b1) begin errors++; $display("FAIL abort_we_n: got %b expected 1", ifa.SRAM_we_n); end
    checks++; if (ifa.SRAM_address !== 18'd0) begin errors++; $display("FAIL abort_addr: got %0d expected 0", ifa.SRAM_address); end
    checks++; if (ifa.coeff_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", ifa.coeff_ready); end
    checks++; if (ifa.state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", ifa.state_dbg); end
    do_reset();
    start_a(1'b0);
    drive_a(16'd5);
    checks++; if (ifa.SRAM_address !== 18'd76800) begin errors++; $display("FAIL restart_addr: got %0d expected 76800", ifa.SRAM_address); end
    checks++; if (ifa.SRAM_write_data !== 16'd40) begin errors++; $display("FAIL restart_data: got %h expected 0028", ifa.SRAM_write_data); end
  endtask

  // Whole small frame; with gaps=1 about half the cycles carry no valid.
  task automatic run_frame_s(input logic q, input logic gaps, input string tag);
    int wbase, bdbase, ddbase, weebase, n, got_n;
    build_exp(q);
    wbase = wr_s_q.size(); bdbase = bd_cnt_s; ddbase = dd_cnt_s; weebase = we_err_s;
    start_s(q);
    for (int i = 0; i < 1024; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        ifs.coeff_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive_s(16'(coeff_pat(i)));
    end
    n = 0;
    while (dd_cnt_s == ddbase && n < 20) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk); #1;
    got_n = wr_s_q.size() - wbase;
    checks++; if (got_n !== 1024) begin errors++; $display("FAIL %s_write_count: got %0d expected 1024", tag, got_n); end
    for (int i = 0; i < 1024; i++)
      if (wbase + i < wr_s_q.size()) begin
        checks++;
        if (wr_s_q[wbase + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_word%0d: got addr %0d data %h expected addr %0d data %h", tag, i,
                   wr_s_q[wbase + i][33:16], wr_s_q[wbase + i][15:0], exp_q[i][33:16], exp_q[i][15:0]);
        end
      end
    if (got_n >= 1024) begin
      checks++; if (wr_s_q[wbase + 512][33:16] !== 18'd1512) begin errors++; $display("FAIL %s_u_base: got %0d expected 1512", tag, wr_s_q[wbase + 512][33:16]); end
      checks++; if (wr_s_q[wbase + 768][33:16] !== 18'd1768) begin errors++; $display("FAIL %s_v_base: got %0d expected 1768", tag, wr_s_q[wbase + 768][33:16]); end
    end
    checks++; if (bd_cnt_s - bdbase !== 16) begin errors++; $display("FAIL %s_block_done_count: got %0d expected 16", tag, bd_cnt_s - bdbase); end
    checks++; if (dd_cnt_s - ddbase !== 1) begin errors++; $display("FAIL %s_dq_done_count: got %0d expected 1", tag, dd_cnt_s - ddbase); end
    checks++; if (dd_cyc !== last_wr_cyc + 1) begin errors++; $display("FAIL %s_dq_done_timing: got cycle %0d expected %0d", tag, dd_cyc, last_wr_cyc + 1); end
    checks++; if (we_err_s - weebase !== 0) begin errors++; $display("FAIL %s_write_timing: got %0d stray/missing writes expected 0", tag, we_err_s - weebase); end
    checks++; if (ifs.state_dbg !== 2'd0) begin errors++; $display("FAIL %s_end_state: got %0d expected 0", tag, ifs.state_dbg); end
    checks++; if (ifs.coeff_ready !== 1'b0) begin errors++; $display("FAIL %s_end_ready: got %b expected 0", tag, ifs.coeff_ready); end
  endtask

  task automatic test_full_frame();
    do_reset();
    run_frame_s(1'b0, 1'b0, "frame");
  endtask

  task automatic test_gaps();
    run_frame_s(1'b0, 1'b1, "gaps");
  endtask

  task automatic test_back_to_back();
    run_frame_s(1'b1, 1'b0, "b2b_q1");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();
    test_reset();
    test_q0_first_block();
    test_q1();
    test_abort_restart();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
